// File: rtl/twos_complement_seq.sv
// Chunk-serial two's-complement unit (pass / negate / abs) with start/busy/done handshake.
// Optional TWOS_OVF_DETECT_EN adds the registered ovf output for negating the most negative value.
module twos_complement_seq #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] inp,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
`ifdef TWOS_OVF_DETECT_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0]    LAST = IW'(N - 1);
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH - 1){1'b0}}};

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("twos_complement_seq: CHUNK must divide WIDTH");
    end
  endgenerate

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             last;
  logic             eff_neg;
  logic [WIDTH-1:0] opreg;
  logic             negop;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [CHUNK-1:0] op_chunk;
  logic [CHUNK:0]   sum;

  // abs negates only when the operand is negative; mode 11 aliases negate
  always_comb begin
    eff_neg = 1'b0;
    unique case (mode)
      2'b00:   eff_neg = 1'b0;
      2'b01:   eff_neg = 1'b1;
      2'b10:   eff_neg = inp[WIDTH-1];
      default: eff_neg = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (idx == LAST) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  always_comb begin
    op_chunk = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == IW'(k)) op_chunk = opreg[k*CHUNK +: CHUNK];
    end
  end

  // pass mode keeps carry at 0, so one adder serves both ops
  assign sum = {1'b0, (negop ? ~op_chunk : op_chunk)} + {{CHUNK{1'b0}}, carry};

  always_ff @(posedge clk) begin
    if (rst) begin
      opreg <= '0;
      negop <= 1'b0;
      carry <= 1'b0;
      idx   <= '0;
      out   <= '0;
      done  <= 1'b0;
`ifdef TWOS_OVF_DETECT_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= last;
      if (accept) begin
        opreg <= inp;
        negop <= eff_neg;
        carry <= eff_neg;
        idx   <= '0;
      end else if (state == RUN) begin
        for (int k = 0; k < N; k++) begin
          if (idx == IW'(k)) out[k*CHUNK +: CHUNK] <= sum[CHUNK-1:0];
        end
        carry <= sum[CHUNK];
        idx   <= idx + IW'(1);
`ifdef TWOS_OVF_DETECT_EN
        if (last) ovf <= negop && (opreg == MINV);
`endif
      end
    end
  end

endmodule

// File: tb/tb_twos_complement_seq.sv
// Bench for twos_complement_seq: CHUNK=16 and CHUNK=64 instances share stimulus,
// checked every cycle against a transaction-level model plus literal expectations.
module tb_twos_complement_seq;

  localparam int W = 64;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   mode  = 2'b00;
  logic [W-1:0] inp   = '0;
  logic         busy0, done0, busy1, done1;
  logic [W-1:0] out0, out1;
`ifdef TWOS_OVF_DETECT_EN
  logic         ovf0, ovf1;
`endif

  always #5 clk = ~clk;

  twos_complement_seq #(.WIDTH(W), .CHUNK(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .inp(inp),
    .busy(busy0), .done(done0), .out(out0)
`ifdef TWOS_OVF_DETECT_EN
    , .ovf(ovf0)
`endif
  );

  twos_complement_seq #(.WIDTH(W), .CHUNK(64)) u_dut64 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .inp(inp),
    .busy(busy1), .done(done1), .out(out1)
`ifdef TWOS_OVF_DETECT_EN
    , .ovf(ovf1)
`endif
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Model: an accepted op completes after n cycles with result = +/- operand
  int           m_cnt[2]  = '{0, 0};
  int           m_lat[2]  = '{4, 1};
  logic         m_done[2] = '{1'b0, 1'b0};
  logic         m_ovf[2]  = '{1'b0, 1'b0};
  logic         m_povf[2] = '{1'b0, 1'b0};
  logic [W-1:0] m_out[2]  = '{64'd0, 64'd0};
  logic [W-1:0] m_res[2]  = '{64'd0, 64'd0};
  logic         m_neg;
  bit           mvalid = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_cnt[i]  = 0;
        m_done[i] = 1'b0;
        m_ovf[i]  = 1'b0;
        m_out[i]  = '0;
      end else begin
        m_done[i] = 1'b0;
        if (m_cnt[i] > 0) begin
          m_cnt[i] = m_cnt[i] - 1;
          if (m_cnt[i] == 0) begin
            m_done[i] = 1'b1;
            m_out[i]  = m_res[i];
            m_ovf[i]  = m_povf[i];
          end
        end else if (start) begin
          m_neg     = (mode == 2'b01) || (mode == 2'b11) || (mode == 2'b10 && inp[W-1]);
          m_res[i]  = m_neg ? -inp : inp;
          m_povf[i] = m_neg && (inp == 64'h8000_0000_0000_0000);
          m_cnt[i]  = m_lat[i];
        end
      end
    end
    mvalid = 1'b1;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("busy16", busy0, (m_cnt[0] != 0));
      chk("done16", done0, m_done[0]);
      if (m_cnt[0] == 0) chk("out16", out0, m_out[0]);
      chk("busy64", busy1, (m_cnt[1] != 0));
      chk("done64", done1, m_done[1]);
      if (m_cnt[1] == 0) chk("out64", out1, m_out[1]);
`ifdef TWOS_OVF_DETECT_EN
      chk("ovf16", ovf0, m_ovf[0]);
      chk("ovf64", ovf1, m_ovf[1]);
`endif
    end
  end

  task automatic applyStimulus(input logic [1:0] m, input logic [W-1:0] v, input bit hold);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    inp   = v;
    @(negedge clk);
    if (!hold) begin
      start = 1'b0;
      mode  = ~m;
      inp   = ~v;
    end
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] exp, input int lat);
    int cyc = 0;
    while (done0 !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_latency"}, cyc, lat);
    chk({name, "_out"}, out0, exp);
    chk({name, "_model"}, m_out[0], exp);
  endtask

  initial begin
    int pulses;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy0, 1'b0);
    chk("reset_done", done0, 1'b0);
    chk("reset_out", out0, 64'd0);
    rst = 1'b0;

    applyStimulus(2'b01, 64'd1, 1'b0);
    @(negedge clk);
    chk("n1_done", done1, 1'b1);
    chk("n1_out", out1, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("neg_one", 64'hFFFF_FFFF_FFFF_FFFF, 3);

    applyStimulus(2'b01, 64'h8000_0000_0000_0000, 1'b0);
    checkOutput("neg_min", 64'h8000_0000_0000_0000, 4);
`ifdef TWOS_OVF_DETECT_EN
    chk("ovf_min", ovf0, 1'b1);
`endif

    applyStimulus(2'b01, 64'd0, 1'b0);
    checkOutput("neg_zero", 64'd0, 4);
`ifdef TWOS_OVF_DETECT_EN
    chk("ovf_zero", ovf0, 1'b0);
`endif

    applyStimulus(2'b10, 64'hFFFF_FFFF_FFFF_FFF6, 1'b0);
    checkOutput("abs_neg", 64'd10, 4);
    applyStimulus(2'b10, 64'd5, 1'b0);
    checkOutput("abs_pos", 64'd5, 4);
    applyStimulus(2'b11, 64'h0000_0000_0001_0000, 1'b0);
    checkOutput("mode11", 64'hFFFF_FFFF_FFFF_0000, 4);

    applyStimulus(2'b01, 64'd3, 1'b0);
    @(negedge clk);
    start = 1'b1;
    mode  = 2'b01;
    inp   = 64'd7;
    @(negedge clk);
    start = 1'b0;
    checkOutput("ignore_busy", 64'hFFFF_FFFF_FFFF_FFFD, 2);

    applyStimulus(2'b01, 64'd3, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy0, 1'b0);
    chk("abort_done", done0, 1'b0);
    chk("abort_out", out0, 64'd0);
    rst = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (done0 === 1'b1) pulses++;
    end
    chk("abort_no_done", pulses, 0);

    applyStimulus(2'b00, 64'h0123_4567_89AB_CDEF, 1'b1);
    checkOutput("pass", 64'h0123_4567_89AB_CDEF, 4);
    mode = 2'b10;
    inp  = 64'hFFFF_FFFF_FFFF_FFFB;
    @(negedge clk);
    chk("b2b_busy", busy0, 1'b1);
    chk("b2b_done_fell", done0, 1'b0);
    start = 1'b0;
    checkOutput("b2b", 64'd5, 4);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
